// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the fifo_flex per-port buffer.
// Used by fifo_flex and fifo_ram.
package fifo_pkg;

    localparam int FIFO_SIZE_DEF = 64;
    localparam int W_WIDTH_DEF   = 32;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port storage array for fifo_flex: synchronous write port, synchronous read port.
// A same-address read and write in one cycle returns the previously stored word.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_SIZE_DEF,
    parameter int WIDTH = W_WIDTH_DEF,
    parameter int AW    = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with registered count, almost-full/empty thresholds and flush.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow error flags.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int FIFO_SIZE = FIFO_SIZE_DEF,
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int AF_LEVEL  = FIFO_SIZE - 4,
    parameter int AE_LEVEL  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fifo_en,
    input  logic                              clr,
    input  logic                              wr_en,
    input  logic [W_WIDTH-1:0]                data_in,
    input  logic                              rd_en,
    output logic [W_WIDTH-1:0]                data_out,
    output logic                              rd_valid,
    output logic [fifo_cnt_w(FIFO_SIZE)-1:0]  count,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int PW = fifo_ptr_w(FIFO_SIZE);
    localparam int CW = fifo_cnt_w(FIFO_SIZE);

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               afull_q, afull_d;
    logic               aempty_q, aempty_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wa, ra;
    logic [W_WIDTH-1:0] ram_rdata;

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write alongside it.
    assign ra = fifo_en & rd_en & ~empty_q;
    assign wa = fifo_en & wr_en & (~full_q | ra);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        full_d     = full_q;
        empty_d    = empty_q;
        afull_d    = afull_q;
        aempty_d   = aempty_q;
        rd_valid_d = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
            empty_d  = 1'b1;
            afull_d  = 1'b0;
            aempty_d = 1'b1;
        end else begin
            if (wa) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (ra) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                rd_valid_d = 1'b1;
            end
            if (wa && !ra) begin
                count_d = count_q + CW'(1);
            end else if (ra && !wa) begin
                count_d = count_q - CW'(1);
            end
            full_d   = (count_d == CW'(FIFO_SIZE));
            empty_d  = (count_d == '0);
            afull_d  = (count_d >= CW'(AF_LEVEL));
            aempty_d = (count_d <= CW'(AE_LEVEL));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    fifo_ram #(
        .DEPTH (FIFO_SIZE),
        .WIDTH (W_WIDTH),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wa & ~clr),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (ra & ~clr),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // The RAM read register is not reset; qualifying with rd_valid keeps data_out at 0 when idle.
    assign data_out     = rd_valid_q ? ram_rdata : '0;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (fifo_en && wr_en && full_q && !ra) begin
                ovf_d = 1'b1;
            end
            if (fifo_en && rd_en && empty_q) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised synchronous FIFO, the next generation of the per-port buffer in the address-decoder datapath. It adds several features: a registered occupancy count, programmable almost-full and almost-empty thresholds, same-cycle read/write at the full boundary, a synchronous flush, and optional sticky overflow/underflow error flags. It sits between the switch ingress logic and the unit address decoder, one instance per port.

## Interface
- FIFO_SIZE, 64: depth in words; power of two, ≥ 4.
- W_WIDTH, 32: word width in bits.
- AF_LEVEL, FIFO_SIZE-4: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_en  in  1  global enable; gates both write and read acceptance.
- clr  in  1  synchronous flush.
- wr_en  in  1  write request.
- data_in  in  W_WIDTH  write data.
- rd_en  in  1  read request.
- data_out  out  W_WIDTH  read data; 0 whenever rd_valid is low.
- rd_valid  out  1  data_out holds a popped word this cycle.
- count  out  $clog2(FIFO_SIZE)+1  current occupancy.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- overflow, underflow  out  1 each  sticky error flags (see Configuration).

## Operation
- Write accept: wa = fifo_en & wr_en & (!full | ra).
- Read accept: ra = fifo_en & rd_en & !empty.
- When empty, a same-cycle write does not satisfy the read (no fall-through).
- On wa, mem[wr_ptr] ← data_in and wr_ptr increments.
- On ra, data_out ← mem[rd_ptr], rd_valid ← 1, and rd_ptr increments. Otherwise data_out ← 0 and rd_valid ← 0.
- Pointers are $clog2(FIFO_SIZE) bits and wrap naturally from FIFO_SIZE-1 to 0.
- count_next = count + wa − ra. It never exceeds FIFO_SIZE and never goes below 0.
- All flags are registered and computed from count_next:
  - full = (count_next == FIFO_SIZE)
  - empty = (count_next == 0)
  - almost_full = (count_next ≥ AF_LEVEL)
  - almost_empty = (count_next ≤ AE_LEVEL)
- Simultaneous wa and ra: count unchanged, flags unchanged; valid at full and at any non-empty level.
- A read is not destructive: memory contents are not cleared on read.
- clr has priority over wr_en and rd_en in the same cycle. It sets pointers and count to 0, empty and almost_empty to 1, all other flags to 0, data_out to 0, and rd_valid to 0. Memory contents are untouched.
- Reset values: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, data_out 0, rd_valid 0, overflow 0, underflow 0.
- Reset asserted mid-operation discards all contents immediately (asynchronous).

## Timing
- Read latency is 1 cycle: rd_en accepted in cycle N gives data_out/rd_valid after edge N.
- Write-to-read: data written at edge N deasserts empty after edge N; the earliest accepted rd_en is in cycle N+1, with data visible after edge N+1.
- Flags and count update on the same edge as the accepted operation.
- No combinational path from any input to any output.

## Configuration
- Macro FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets when fifo_en & wr_en & full & !ra.
  - underflow sets when fifo_en & rd_en & empty.
  - Both flags are sticky until clr or reset.
- Undefined: overflow and underflow are tied to 0 and no flag logic is built.

## Structure
- Package fifo_pkg holds the default depth/width localparams and the count/pointer width function.
- Sub-module fifo_ram: dual-port storage array, FIFO_SIZE × W_WIDTH, with a synchronous write port and a synchronous read port. fifo_flex holds pointers, count, flags and error logic.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 and read 3 words → data_out 0x11, 0x22, 0x33 on consecutive cycles with rd_valid=1, count 3→0, empty=1 at the end.
- Fill 64 words → full=1 and count=64 after the 64th edge, almost_full first asserted at count 60. Then a simultaneous wr/rd while full → write accepted, count stays 64, oldest word read out.
- Write 0xAA when full without a read → write rejected, count stays 64, overflow=1 (macro defined) or 0 (undefined).
- Read while empty → rd_valid=0, data_out=0, underflow=1 (macro defined). Then clr → underflow=0.
- Write 70 words interleaved with 70 reads → pointers wrap and data order is preserved across the wrap.
- Half-fill with 32 words, pulse clr together with wr_en → count=0, empty=1, the write is dropped. Assert rst_n low mid-burst → all outputs at reset values asynchronously.
